// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_arb_pkg : shared types and round-robin winner selection for the arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package bus_arb_pkg;

  localparam int MaxHosts = 8;

  typedef logic [2:0] host_idx_t;

  // Unused request bits above NrHosts are zero, so scanning modulo MaxHosts
  // picks the same winner as scanning modulo NrHosts.
  function automatic host_idx_t rr_pick(input logic [MaxHosts-1:0] req,
                                        input host_idx_t ptr);
    host_idx_t winner;
    host_idx_t idx;
    logic      found;
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < MaxHosts; i++) begin
      idx = ptr + host_idx_t'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arb_id_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_arb_id_fifo : ordering FIFO holding the host index of each outstanding
//                   request; Depth must be a power of two, 1..8
// Revision        : 1.0
// ---------------------------------------------------------------------------
module bus_arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push,
  input  logic      pop,
  input  host_idx_t wdata,
  output host_idx_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth) + 1;

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  host_idx_t       mem_q [Depth];
  host_idx_t       mem_d [Depth];
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (do_pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_host_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_host_arbiter : round-robin sharing of one device request port between
//                    NrHosts hosts, responses routed back in grant order.
//                    Optional host locking via BUS_ARB_LOCK_EN.
// Revision         : 1.0
// ---------------------------------------------------------------------------
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    host_req_i    [NrHosts],
  output logic                    host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
  input  logic                    host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
  output logic                    host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
  output logic                    host_err_o    [NrHosts],
`ifdef BUS_ARB_LOCK_EN
  input  logic                    host_lock_i   [NrHosts],
`endif

  output logic                    out_req_o,
  input  logic                    out_gnt_i,
  output logic [AddressWidth-1:0] out_addr_o,
  output logic                    out_we_o,
  output logic [DataWidth/8-1:0]  out_be_o,
  output logic [DataWidth-1:0]    out_wdata_o,
  input  logic                    out_rvalid_i,
  input  logic [DataWidth-1:0]    out_rdata_i,
  input  logic                    out_err_i,

  output logic                    unexp_rsp_o
);

  localparam int PtrW = $clog2(NrHosts);
  typedef logic [PtrW-1:0] ptr_t;

  ptr_t                rr_ptr_q, rr_ptr_d;
  logic                unexp_q, unexp_d;
  logic [MaxHosts-1:0] req_vec;
  host_idx_t           win;
  host_idx_t           head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                grant;
  logic                rsp_ok;
  logic                ptr_frozen;

`ifdef BUS_ARB_LOCK_EN
  logic      lock_q, lock_d;
  host_idx_t lock_idx_q, lock_idx_d;
  logic      win_lock;
  logic      held_lock;

  always_comb begin
    win_lock  = 1'b0;
    held_lock = 1'b0;
    for (int h = 0; h < NrHosts; h++) begin
      if (host_idx_t'(h) == win)        win_lock  = host_lock_i[h];
      if (host_idx_t'(h) == lock_idx_q) held_lock = host_lock_i[h];
    end
  end

  // Release only on an idle cycle of the owner with its lock dropped.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (!lock_q) begin
      if (grant && win_lock) begin
        lock_d     = 1'b1;
        lock_idx_d = win;
      end
    end else if (!grant && !held_lock) begin
      lock_d = 1'b0;
    end
  end

  assign ptr_frozen = lock_q;
`else
  assign ptr_frozen = 1'b0;
`endif

  always_comb begin
    req_vec = '0;
    for (int h = 0; h < NrHosts; h++) begin
      req_vec[h] = host_req_i[h];
`ifdef BUS_ARB_LOCK_EN
      if (lock_q && (host_idx_t'(h) != lock_idx_q)) req_vec[h] = 1'b0;
`endif
    end
  end

  assign win       = rr_pick(req_vec, host_idx_t'(rr_ptr_q));
  // Reset gating keeps every output at zero while rst_ni is low.
  assign out_req_o = rst_ni & (|req_vec) & ~fifo_full;
  assign grant     = out_req_o & out_gnt_i;
  assign rsp_ok    = out_rvalid_i & ~fifo_empty;

  always_comb begin
    out_addr_o  = '0;
    out_we_o    = 1'b0;
    out_be_o    = '0;
    out_wdata_o = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (out_req_o && (host_idx_t'(h) == win)) begin
        out_addr_o  = host_addr_i[h];
        out_we_o    = host_we_i[h];
        out_be_o    = host_be_i[h];
        out_wdata_o = host_wdata_i[h];
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h]    = grant && (host_idx_t'(h) == win);
      host_rvalid_o[h] = rsp_ok && (host_idx_t'(h) == head);
      host_rdata_o[h]  = host_rvalid_o[h] ? out_rdata_i : '0;
      host_err_o[h]    = host_rvalid_o[h] & out_err_i;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant && !ptr_frozen) begin
      rr_ptr_d = (win == host_idx_t'(NrHosts - 1)) ? '0 : ptr_t'(win + host_idx_t'(1));
    end
    unexp_d = unexp_q | (out_rvalid_i & fifo_empty);
  end

  assign unexp_rsp_o = unexp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      unexp_q    <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      unexp_q    <= unexp_d;
`ifdef BUS_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  bus_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (grant),
    .pop    (rsp_ok),
    .wdata  (win),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_bus_host_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_host_arbiter : directed self-checking bench for bus_host_arbiter
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_bus_host_arbiter;

  localparam int NH = 2;
  localparam logic [31:0] ADDR0 = 32'h0000_1000;
  localparam logic [31:0] ADDR1 = 32'h0000_2000;
  localparam logic [31:0] RSP0  = 32'hFFFF_1000;
  localparam logic [31:0] RSP1  = 32'hFFFF_2000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        host_req    [NH];
  logic        host_gnt    [NH];
  logic [31:0] host_addr   [NH];
  logic        host_we     [NH];
  logic [3:0]  host_be     [NH];
  logic [31:0] host_wdata  [NH];
  logic        host_rvalid [NH];
  logic [31:0] host_rdata  [NH];
  logic        host_err    [NH];
`ifdef BUS_ARB_LOCK_EN
  logic        host_lock   [NH];
`endif
  logic        out_req;
  logic        out_gnt;
  logic [31:0] out_addr;
  logic        out_we;
  logic [3:0]  out_be;
  logic [31:0] out_wdata;
  logic        out_rvalid;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        unexp;

  logic [1:0]  gnt_v;
  logic [1:0]  rv_v;
  int          checks   = 0;
  int          failures = 0;

  assign gnt_v = {host_gnt[1], host_gnt[0]};
  assign rv_v  = {host_rvalid[1], host_rvalid[0]};

  always #5 clk = ~clk;

  bus_host_arbiter #(
    .NrHosts        (NH),
    .DataWidth      (32),
    .AddressWidth   (32),
    .MaxOutstanding (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .host_req_i    (host_req),
    .host_gnt_o    (host_gnt),
    .host_addr_i   (host_addr),
    .host_we_i     (host_we),
    .host_be_i     (host_be),
    .host_wdata_i  (host_wdata),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .host_err_o    (host_err),
`ifdef BUS_ARB_LOCK_EN
    .host_lock_i   (host_lock),
`endif
    .out_req_o     (out_req),
    .out_gnt_i     (out_gnt),
    .out_addr_o    (out_addr),
    .out_we_o      (out_we),
    .out_be_o      (out_be),
    .out_wdata_o   (out_wdata),
    .out_rvalid_i  (out_rvalid),
    .out_rdata_i   (out_rdata),
    .out_err_i     (out_err),
    .unexp_rsp_o   (unexp)
  );

  task automatic idle_inputs();
    for (int h = 0; h < NH; h++) begin
      host_req[h]   = 1'b0;
      host_we[h]    = (h == 0);
      host_be[h]    = 4'hF;
      host_wdata[h] = 32'hA5A5_0000 + h;
`ifdef BUS_ARB_LOCK_EN
      host_lock[h]  = 1'b0;
`endif
    end
    host_addr[0] = ADDR0;
    host_addr[1] = ADDR1;
    out_gnt    = 1'b0;
    out_rvalid = 1'b0;
    out_rdata  = '0;
    out_err    = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  // Drive one cycle's inputs just after the edge, then settle to mid-cycle.
  task automatic cyc(input logic r0, input logic r1, input logic g,
                     input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    host_req[0] = r0;
    host_req[1] = r1;
    out_gnt     = g;
    out_rvalid  = rv;
    out_rdata   = rd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    host_req[0] = 1'b1;
    host_req[1] = 1'b1;
    out_gnt     = 1'b1;
    @(negedge clk);
    checks++;
    if (out_req !== 1'b0 || gnt_v !== 2'b00 || out_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_req: req=%b gnt=%b addr=%h required 0", out_req, gnt_v, out_addr);
    end
    checks++;
    if (rv_v !== 2'b00 || unexp !== 1'b0 || host_rdata[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_rsp: rvalid=%b unexp=%b rdata0=%h required 0", rv_v, unexp, host_rdata[0]);
    end
    do_reset();
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_g;
    logic [1:0]  exp_rv;
    logic [31:0] rd;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      rd = (k == 0) ? 32'h0 : (((k - 1) % 2 == 0) ? RSP0 : RSP1);
      cyc(1'b1, 1'b1, 1'b1, k > 0, rd);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (gnt_v !== exp_g || out_addr !== ((k % 2 == 0) ? ADDR0 : ADDR1)) begin
        failures++;
        $display("FAIL fair_gnt k=%0d: gnt=%b addr=%h required gnt=%b", k, gnt_v, out_addr, exp_g);
      end
      if (k > 0) begin
        exp_rv = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (rv_v !== exp_rv || host_rdata[(k - 1) % 2] !== rd || host_rdata[k % 2] !== 32'h0) begin
          failures++;
          $display("FAIL fair_rsp k=%0d: rvalid=%b rdata0=%h rdata1=%h required rvalid=%b data=%h",
                   k, rv_v, host_rdata[0], host_rdata[1], exp_rv, rd);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, RSP1);
    checks++;
    if (rv_v !== 2'b10 || host_rdata[1] !== RSP1) begin
      failures++;
      $display("FAIL fair_drain: rvalid=%b rdata1=%h required 10 %h", rv_v, host_rdata[1], RSP1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, RSP0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (gnt_v !== 2'b00 || out_req !== 1'b1 || out_addr !== ADDR1) begin
        failures++;
        $display("FAIL bp_hold i=%0d: gnt=%b req=%b addr=%h required 00 1 %h", i, gnt_v, out_req, out_addr, ADDR1);
      end
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (gnt_v !== 2'b10) begin
      failures++;
      $display("FAIL bp_first_gnt: gnt=%b required 10", gnt_v);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, RSP1);
    checks++;
    if (gnt_v !== 2'b01 || rv_v !== 2'b10 || host_rdata[1] !== RSP1) begin
      failures++;
      $display("FAIL bp_ptr: gnt=%b rvalid=%b rdata1=%h required 01 10 %h", gnt_v, rv_v, host_rdata[1], RSP1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, RSP0);
    checks++;
    if (rv_v !== 2'b01 || host_rdata[0] !== RSP0) begin
      failures++;
      $display("FAIL bp_drain: rvalid=%b rdata0=%h required 01 %h", rv_v, host_rdata[0], RSP0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_fifo_full();
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (gnt_v !== 2'b01 || out_req !== 1'b1) begin
      failures++;
      $display("FAIL full_g1: gnt=%b req=%b required 01 1", gnt_v, out_req);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (gnt_v !== 2'b10) begin
      failures++;
      $display("FAIL full_g2: gnt=%b required 10", gnt_v);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (out_req !== 1'b0 || gnt_v !== 2'b00) begin
      failures++;
      $display("FAIL full_block: req=%b gnt=%b required 0 00", out_req, gnt_v);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, RSP0);
    checks++;
    if (out_req !== 1'b0 || rv_v !== 2'b01 || host_rdata[0] !== RSP0) begin
      failures++;
      $display("FAIL full_pop: req=%b rvalid=%b rdata0=%h required 0 01 %h", out_req, rv_v, host_rdata[0], RSP0);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (out_req !== 1'b1 || gnt_v !== 2'b01) begin
      failures++;
      $display("FAIL full_resume: req=%b gnt=%b required 1 01", out_req, gnt_v);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, RSP1);
    checks++;
    if (out_req !== 1'b0 || rv_v !== 2'b10 || host_rdata[1] !== RSP1) begin
      failures++;
      $display("FAIL full_pop2: req=%b rvalid=%b rdata1=%h required 0 10 %h", out_req, rv_v, host_rdata[1], RSP1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, RSP0);
    checks++;
    if (rv_v !== 2'b01 || host_rdata[0] !== RSP0) begin
      failures++;
      $display("FAIL full_pop3: rvalid=%b rdata0=%h required 01 %h", rv_v, host_rdata[0], RSP0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (unexp !== 1'b0) begin
      failures++;
      $display("FAIL full_unexp: unexp=%b required 0", unexp);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, RSP0);
    checks++;
    if (gnt_v !== 2'b10 || rv_v !== 2'b01 || host_rdata[0] !== RSP0 || host_rdata[1] !== 32'h0) begin
      failures++;
      $display("FAIL pp_same: gnt=%b rvalid=%b rdata0=%h rdata1=%h required 10 01 %h 0",
               gnt_v, rv_v, host_rdata[0], host_rdata[1], RSP0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (gnt_v !== 2'b01) begin
      failures++;
      $display("FAIL pp_second: gnt=%b required 01", gnt_v);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (out_req !== 1'b0) begin
      failures++;
      $display("FAIL pp_count: req=%b required 0", out_req);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, RSP1);
    checks++;
    if (rv_v !== 2'b10 || host_rdata[1] !== RSP1) begin
      failures++;
      $display("FAIL pp_head: rvalid=%b rdata1=%h required 10 %h", rv_v, host_rdata[1], RSP1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, RSP0);
    checks++;
    if (rv_v !== 2'b01 || host_rdata[0] !== RSP0) begin
      failures++;
      $display("FAIL pp_tail: rvalid=%b rdata0=%h required 01 %h", rv_v, host_rdata[0], RSP0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_unexpected();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if (rv_v !== 2'b00 || host_rdata[0] !== 32'h0 || host_rdata[1] !== 32'h0 || unexp !== 1'b0) begin
      failures++;
      $display("FAIL unexp_drop: rvalid=%b rdata0=%h rdata1=%h unexp=%b required 00 0 0 0",
               rv_v, host_rdata[0], host_rdata[1], unexp);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (unexp !== 1'b1) begin
      failures++;
      $display("FAIL unexp_set: unexp=%b required 1", unexp);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (unexp !== 1'b1) begin
      failures++;
      $display("FAIL unexp_sticky: unexp=%b required 1", unexp);
    end

    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, RSP0);
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if (out_req !== 1'b0 || gnt_v !== 2'b00 || rv_v !== 2'b00 || host_rdata[0] !== 32'h0 ||
        out_addr !== 32'h0 || unexp !== 1'b0) begin
      failures++;
      $display("FAIL midrst: req=%b gnt=%b rvalid=%b rdata0=%h addr=%h unexp=%b required all 0",
               out_req, gnt_v, rv_v, host_rdata[0], out_addr, unexp);
    end
    @(posedge clk);
    #1;
    rst_ni      = 1'b1;
    host_req[0] = 1'b0;
    host_req[1] = 1'b0;
    out_gnt     = 1'b0;
    out_rvalid  = 1'b1;
    out_rdata   = RSP1;
    @(negedge clk);
    checks++;
    if (rv_v !== 2'b00) begin
      failures++;
      $display("FAIL postrst_drop: rvalid=%b required 00", rv_v);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (unexp !== 1'b1) begin
      failures++;
      $display("FAIL postrst_unexp: unexp=%b required 1", unexp);
    end
  endtask

`ifdef BUS_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    @(posedge clk);
    #1 host_lock[1] = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (gnt_v !== 2'b10) begin
      failures++;
      $display("FAIL lock_take: gnt=%b required 10", gnt_v);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, RSP1);
      checks++;
      if (gnt_v !== 2'b10 || rv_v !== 2'b10) begin
        failures++;
        $display("FAIL lock_hold i=%0d: gnt=%b rvalid=%b required 10 10", i, gnt_v, rv_v);
      end
    end
    @(posedge clk);
    #1;
    host_lock[1] = 1'b0;
    host_req[0]  = 1'b1;
    host_req[1]  = 1'b0;
    out_gnt      = 1'b1;
    out_rvalid   = 1'b1;
    out_rdata    = RSP1;
    @(negedge clk);
    checks++;
    if (host_gnt[1] !== 1'b0 || rv_v !== 2'b10) begin
      failures++;
      $display("FAIL lock_drop: gnt=%b rvalid=%b required gnt1=0 rvalid=10", gnt_v, rv_v);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (gnt_v !== 2'b01) begin
      failures++;
      $display("FAIL lock_release: gnt=%b required 01", gnt_v);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, RSP0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_fifo_full();
    test_push_pop();
    test_unexpected();
`ifdef BUS_ARB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
